// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad code entry with debounce, submit check and lockout
module keypad_entry_ctrl #(
  parameter int          DEB_CYC  = 4,
  parameter int          LOCK_CYC = 16,
  parameter int          MAX_FAIL = 3,
  parameter logic [15:0] CODE     = 16'h1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] Key,
  output logic [15:0] entry,
  output logic [2:0]  entry_cnt,
  output logic        unlock,
  output logic        fail,
  output logic        locked,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    WAIT_REL,
    CHECK,
    LOCKOUT
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] code_q, code_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  entry_cnt_q, entry_cnt_d;
  logic        unlock_q, unlock_d;
  logic        fail_q, fail_d;
  logic        locked_q, locked_d;
  logic        busy_q, busy_d;

  logic        key_valid;
  logic        deb_done;
  logic [3:0]  digit;
  logic [2:0]  fail_inc;

  always_comb begin
    key_valid = (Key != 12'd0) && ((Key & (Key - 12'd1)) == 12'd0);
    // Counter value after this cycle's increment reaches DEB_CYC-1
    deb_done  = (int'(deb_cnt_q) + 2) >= DEB_CYC;
    fail_inc  = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;
    digit     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (code_q[i]) digit = 4'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    deb_cnt_d   = deb_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    entry_d     = entry_q;
    entry_cnt_d = entry_cnt_q;
    unlock_d    = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d   = DEBOUNCE;
          code_d    = Key;
          deb_cnt_d = 8'd0;
        end
      end
      DEBOUNCE: begin
        if (Key != code_q) begin
          state_d = IDLE;
        end else if (deb_done) begin
          if (code_q[11]) begin
            state_d = CHECK;
          end else begin
            state_d = WAIT_REL;
            if (code_q[10]) begin
              entry_d     = 16'd0;
              entry_cnt_d = 3'd0;
            end else begin
              entry_d     = {entry_q[11:0], digit};
              entry_cnt_d = (entry_cnt_q == 3'd4) ? 3'd4 : entry_cnt_q + 3'd1;
            end
          end
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      CHECK: begin
        entry_d     = 16'd0;
        entry_cnt_d = 3'd0;
        if (entry_cnt_q == 3'd4 && entry_q == CODE) begin
          unlock_d   = 1'b1;
          fail_cnt_d = 3'd0;
          state_d    = WAIT_REL;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_inc;
          if (int'(fail_inc) == MAX_FAIL) begin
            state_d    = LOCKOUT;
            lock_cnt_d = 16'd0;
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      LOCKOUT: begin
        if (int'(lock_cnt_q) == LOCK_CYC - 1) begin
          fail_cnt_d = 3'd0;
          state_d    = WAIT_REL;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      WAIT_REL: begin
        if (Key == 12'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    locked_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= 12'd0;
      deb_cnt_q   <= 8'd0;
      lock_cnt_q  <= 16'd0;
      fail_cnt_q  <= 3'd0;
      entry_q     <= 16'd0;
      entry_cnt_q <= 3'd0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      deb_cnt_q   <= deb_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      entry_q     <= entry_d;
      entry_cnt_q <= entry_cnt_d;
      unlock_q    <= unlock_d;
      fail_q      <= fail_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
    end
  end

  assign entry     = entry_q;
  assign entry_cnt = entry_cnt_q;
  assign unlock    = unlock_q;
  assign fail      = fail_q;
  assign locked    = locked_q;
  assign busy      = busy_q;

endmodule
